tlb_cmd_seq: RTL
================

TLB_CMD_SEQ -- requirements
Module: tlb_cmd_seq

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, number of TLB entries (power of 2).
REQ-002 SHALL have parameter IDX_W, default 4, equal to log2(TLB_ENTRIES).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  TLB instruction request.
REQ-006 cmd_op  in  2  00 SRCH, 01 RD, 10 WR, 11 FILL.
REQ-007 cmd_ready  out  1  request accepted when cmd_valid&&cmd_ready at an edge.
REQ-008 flush  in  1  pipeline flush, aborts any operation.
REQ-009 csr_index  in  IDX_W  TLBIDX.Index.
REQ-010 csr_vpn  in  19  TLBEHI[31:13].
REQ-011 csr_asid  in  10  ASID.ASID.
REQ-012 tlb_rd_en / tlb_rd_idx  out  1 / IDX_W  array read port, data returned next cycle.
REQ-013 tlb_rd_e, tlb_rd_g  in  1 each  returned entry E and G bits.
REQ-014 tlb_rd_vpn / tlb_rd_asid  in  19 / 10  returned entry VPPN and ASID.
REQ-015 tlb_we / tlb_wr_idx  out  1 / IDX_W  array write strobe and index (write data supplied by CSRs directly).
REQ-016 tlbrd_en / tlb_vpn_rd  out  1 / 19  TLBEHI update strobe and VPN.
REQ-017 rd_invalid  out  1  pulse with tlbrd_en when the read entry has E=0.
REQ-018 srch_done / srch_hit / srch_idx  out  1 / 1 / IDX_W  search result.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 SHALL implement states IDLE, SCAN, RD_WAIT, RD_OUT, WRITE, SRCH_OUT.
REQ-021 cmd_ready SHALL equal (state==IDLE)&&!flush; accept edge defines cycle 0.
REQ-022 SRCH: IDLE->SCAN; cycle 1+i SHALL drive tlb_rd_en=1, tlb_rd_idx=i, for i = 0 to TLB_ENTRIES-1.
REQ-023 Entry returned in cycle 2+i SHALL hit iff tlb_rd_e && tlb_rd_vpn==csr_vpn && (tlb_rd_g || tlb_rd_asid==csr_asid).
REQ-024 First hit at entry k: stop issuing reads, go to SRCH_OUT; cycle 3+k SHALL pulse srch_done=1, srch_hit=1, srch_idx=k; at most one extra read (index k+1) is permitted.
REQ-025 No hit after entry TLB_ENTRIES-1: cycle TLB_ENTRIES+2 SHALL pulse srch_done=1, srch_hit=0, srch_idx=0.
REQ-026 Scan index counter SHALL stop at TLB_ENTRIES-1, with no wrap and no read beyond the last entry.
REQ-027 RD: cycle 1 tlb_rd_en=1, tlb_rd_idx=csr_index sampled at cycle 0; RD_WAIT captures data in cycle 2; RD_OUT cycle 3 SHALL pulse tlbrd_en=1.
REQ-028 In RD_OUT, tlb_vpn_rd SHALL be the captured VPN if E=1; if E=0, tlb_vpn_rd SHALL be 0 and rd_invalid=1.
REQ-029 WR: cycle 1 SHALL pulse tlb_we=1, tlb_wr_idx=csr_index sampled at cycle 0.
REQ-030 FILL: cycle 1 SHALL pulse tlb_we=1, tlb_wr_idx=fill counter value sampled at cycle 0.
REQ-031 Fill counter SHALL be IDX_W bits, increment every cycle, and wrap TLB_ENTRIES-1 -> 0.
REQ-032 SRCH_OUT, RD_OUT and WRITE SHALL each last one cycle, then return to IDLE; back-to-back accept SHALL be possible in the following cycle.
REQ-033 flush SHALL force the next state to IDLE from any state and SHALL combinationally suppress tlb_rd_en, tlb_we, tlbrd_en, rd_invalid and srch_done in the flush cycle.
REQ-034 Strobes SHALL be single-cycle; tlb_rd_en and tlb_we SHALL never be high in the same cycle.
REQ-035 tlb_vpn_rd, srch_hit and srch_idx SHALL be 0 whenever their strobe is low.

Reset
REQ-036 On rst: state IDLE, fill counter 0, scan index 0, captured data 0; all outputs 0 except cmd_ready=1 once rst deasserts.
REQ-037 rst mid-operation SHALL abort immediately with no further strobes.

Structure
REQ-038 Shared package tlb_pkg SHALL hold the cmd_op encodings, the state enumeration, TLB_ENTRIES, IDX_W and the VPN width (19).
REQ-039 Hit comparison SHALL be a combinational sub-module tlb_entry_match; the FSM and counters stay in tlb_cmd_seq.

Verification
REQ-040 SRCH, entry 5 E=1, VPN=0x1234A, G=0, ASID=0x3 matches CSRs -> srch_done cycle 8, hit=1, idx=5.
REQ-041 SRCH, all entries E=0 -> srch_done cycle 18, hit=0; exactly 16 reads, idx 0..15.
REQ-042 RD idx 7, entry E=1, VPN=0x7FFFF -> tlbrd_en cycle 3, tlb_vpn_rd=0x7FFFF, rd_invalid=0; repeat with E=0 -> vpn 0, rd_invalid=1.
REQ-043 FILL accepted when fill counter=15 -> tlb_we cycle 1, idx 15; counter 0 next cycle.
REQ-044 SRCH then flush at cycle 4 -> no srch_done, busy=0 at cycle 5, cmd_ready=1; flush with cmd_valid in IDLE -> not accepted.
REQ-045 rst asserted during SCAN -> all outputs 0 asynchronously; next SRCH starts from idx 0.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB instruction sequencer: command encodings,
// sequencer states and the TLB geometry constants.
package tlb_pkg;

   localparam int TLB_ENTRIES = 16;
   localparam int IDX_W       = 4;
   localparam int VPN_W       = 19;
   localparam int ASID_W      = 10;

   typedef enum logic [1:0] {
      OP_SRCH = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_FILL = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SCAN     = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_RD_OUT   = 3'd3,
      ST_WRITE    = 3'd4,
      ST_SRCH_OUT = 3'd5
   } state_e;

endpackage

// File: rtl/tlb_entry_match.sv
// Combinational hit test of one returned TLB entry against the current
// TLBEHI VPN and ASID: valid entry, equal VPN, and either global or same ASID.
module tlb_entry_match
   import tlb_pkg::*;
(
   input  logic              i_e,
   input  logic              i_g,
   input  logic [VPN_W-1:0]  i_vpn,
   input  logic [ASID_W-1:0] i_asid,
   input  logic [VPN_W-1:0]  i_csr_vpn,
   input  logic [ASID_W-1:0] i_csr_asid,
   output logic              o_hit
);

   logic w_vpn_eq;
   logic w_asid_ok;

   assign w_vpn_eq  = (i_vpn == i_csr_vpn);
   assign w_asid_ok = i_g | (i_asid == i_csr_asid);
   assign o_hit     = i_e & w_vpn_eq & w_asid_ok;

endmodule

// File: rtl/tlb_cmd_seq.sv
// TLB instruction sequencer: runs TLBSRCH (linear scan of the array through
// its one-cycle-latency read port), TLBRD, TLBWR and TLBFILL. Flush aborts
// any operation and masks all strobes in the same cycle.
module tlb_cmd_seq
   import tlb_pkg::*;
#(
   parameter int TLB_ENTRIES = tlb_pkg::TLB_ENTRIES,
   parameter int IDX_W       = tlb_pkg::IDX_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   output logic              cmd_ready,
   input  logic              flush,
   input  logic [IDX_W-1:0]  csr_index,
   input  logic [VPN_W-1:0]  csr_vpn,
   input  logic [ASID_W-1:0] csr_asid,
   output logic              tlb_rd_en,
   output logic [IDX_W-1:0]  tlb_rd_idx,
   input  logic              tlb_rd_e,
   input  logic              tlb_rd_g,
   input  logic [VPN_W-1:0]  tlb_rd_vpn,
   input  logic [ASID_W-1:0] tlb_rd_asid,
   output logic              tlb_we,
   output logic [IDX_W-1:0]  tlb_wr_idx,
   output logic              tlbrd_en,
   output logic [VPN_W-1:0]  tlb_vpn_rd,
   output logic              rd_invalid,
   output logic              srch_done,
   output logic              srch_hit,
   output logic [IDX_W-1:0]  srch_idx,
   output logic              busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);
   localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
   localparam logic [VPN_W-1:0] ZERO_VPN = {VPN_W{1'b0}};

   state_e              r_state;
   state_e              w_next_raw;
   state_e              w_next;
   cmd_op_e             w_op;

   logic [IDX_W-1:0]    r_fill_cnt;
   logic [IDX_W-1:0]    r_scan_idx;   // next entry to read
   logic                r_scan_end;   // last entry already read
   logic                r_chk_vld;    // read data arriving this cycle
   logic [IDX_W-1:0]    r_chk_idx;    // entry whose data is arriving
   logic                r_hit;
   logic [IDX_W-1:0]    r_hit_idx;
   logic [IDX_W-1:0]    r_op_idx;     // index sampled at accept
   logic                r_rd_issued;
   logic                r_cap_e;
   logic [VPN_W-1:0]    r_cap_vpn;

   logic                w_cmd_ready;
   logic                w_accept;
   logic                w_match;
   logic                w_hit;
   logic                w_scan_last;

   logic                w_rd_en_raw;
   logic [IDX_W-1:0]    w_rd_idx_raw;
   logic                w_we_raw;
   logic [IDX_W-1:0]    w_wr_idx_raw;
   logic                w_tlbrd_raw;
   logic [VPN_W-1:0]    w_vpn_rd_raw;
   logic                w_inv_raw;
   logic                w_done_raw;
   logic                w_hit_raw;
   logic [IDX_W-1:0]    w_sidx_raw;
   logic                w_pass;

   assign w_op        = cmd_op_e'(cmd_op);
   assign w_cmd_ready = (r_state == ST_IDLE) & ~flush & ~rst;
   assign w_accept    = cmd_valid & w_cmd_ready;

   tlb_entry_match u_match (
      .i_e        (tlb_rd_e),
      .i_g        (tlb_rd_g),
      .i_vpn      (tlb_rd_vpn),
      .i_asid     (tlb_rd_asid),
      .i_csr_vpn  (csr_vpn),
      .i_csr_asid (csr_asid),
      .o_hit      (w_match)
   );

   assign w_hit       = (r_state == ST_SCAN) & r_chk_vld & w_match;
   assign w_scan_last = r_chk_vld & (r_chk_idx == LAST_IDX);

   // Next-state selection; flush overrides everything back to IDLE.
   always_comb begin
      w_next_raw = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (w_op)
                  OP_SRCH: w_next_raw = ST_SCAN;
                  OP_RD:   w_next_raw = ST_RD_WAIT;
                  OP_WR:   w_next_raw = ST_WRITE;
                  OP_FILL: w_next_raw = ST_WRITE;
                  default: w_next_raw = ST_IDLE;
               endcase
            end else begin
               w_next_raw = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (w_hit || w_scan_last) begin
               w_next_raw = ST_SRCH_OUT;
            end else begin
               w_next_raw = ST_SCAN;
            end
         end
         ST_RD_WAIT: begin
            if (r_rd_issued) begin
               w_next_raw = ST_RD_OUT;
            end else begin
               w_next_raw = ST_RD_WAIT;
            end
         end
         ST_RD_OUT:   w_next_raw = ST_IDLE;
         ST_WRITE:    w_next_raw = ST_IDLE;
         ST_SRCH_OUT: w_next_raw = ST_IDLE;
         default:     w_next_raw = ST_IDLE;
      endcase
      if (flush) begin
         w_next = ST_IDLE;
      end else begin
         w_next = w_next_raw;
      end
   end

   // State-decoded strobes and data before flush masking.
   always_comb begin
      w_rd_en_raw  = 1'b0;
      w_rd_idx_raw = ZERO_IDX;
      w_we_raw     = 1'b0;
      w_wr_idx_raw = ZERO_IDX;
      w_tlbrd_raw  = 1'b0;
      w_vpn_rd_raw = ZERO_VPN;
      w_inv_raw    = 1'b0;
      w_done_raw   = 1'b0;
      w_hit_raw    = 1'b0;
      w_sidx_raw   = ZERO_IDX;
      case (r_state)
         ST_SCAN: begin
            w_rd_en_raw  = ~r_scan_end;
            w_rd_idx_raw = r_scan_end ? ZERO_IDX : r_scan_idx;
         end
         ST_RD_WAIT: begin
            w_rd_en_raw  = ~r_rd_issued;
            w_rd_idx_raw = r_rd_issued ? ZERO_IDX : r_op_idx;
         end
         ST_WRITE: begin
            w_we_raw     = 1'b1;
            w_wr_idx_raw = r_op_idx;
         end
         ST_RD_OUT: begin
            w_tlbrd_raw  = 1'b1;
            w_vpn_rd_raw = r_cap_e ? r_cap_vpn : ZERO_VPN;
            w_inv_raw    = ~r_cap_e;
         end
         ST_SRCH_OUT: begin
            w_done_raw   = 1'b1;
            w_hit_raw    = r_hit;
            w_sidx_raw   = r_hit ? r_hit_idx : ZERO_IDX;
         end
         default: begin
            w_rd_en_raw  = 1'b0;
         end
      endcase
   end

   assign w_pass     = ~flush;
   assign cmd_ready  = w_cmd_ready;
   assign busy       = (r_state != ST_IDLE);
   assign tlb_rd_en  = w_rd_en_raw & w_pass;
   assign tlb_rd_idx = w_pass ? w_rd_idx_raw : ZERO_IDX;
   assign tlb_we     = w_we_raw & w_pass;
   assign tlb_wr_idx = w_pass ? w_wr_idx_raw : ZERO_IDX;
   assign tlbrd_en   = w_tlbrd_raw & w_pass;
   assign tlb_vpn_rd = w_pass ? w_vpn_rd_raw : ZERO_VPN;
   assign rd_invalid = w_inv_raw & w_pass;
   assign srch_done  = w_done_raw & w_pass;
   assign srch_hit   = w_hit_raw & w_pass;
   assign srch_idx   = w_pass ? w_sidx_raw : ZERO_IDX;

   // Sequencer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Free-running fill victim counter, wraps at the last entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fill_cnt <= ZERO_IDX;
      end else begin
         r_fill_cnt <= r_fill_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
      end
   end

   // Search scan: issue index saturates at the last entry, and the data
   // pipeline tracks which entry is being compared this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan_idx <= ZERO_IDX;
         r_scan_end <= 1'b0;
         r_chk_vld  <= 1'b0;
         r_chk_idx  <= ZERO_IDX;
         r_hit      <= 1'b0;
         r_hit_idx  <= ZERO_IDX;
      end else if (w_accept) begin
         r_scan_idx <= ZERO_IDX;
         r_scan_end <= 1'b0;
         r_chk_vld  <= 1'b0;
         r_chk_idx  <= ZERO_IDX;
         r_hit      <= 1'b0;
         r_hit_idx  <= ZERO_IDX;
      end else if (r_state == ST_SCAN) begin
         r_chk_vld <= ~r_scan_end;
         r_chk_idx <= r_scan_idx;
         if (r_scan_idx == LAST_IDX) begin
            r_scan_end <= 1'b1;
         end else begin
            r_scan_idx <= r_scan_idx + {{(IDX_W-1){1'b0}}, 1'b1};
         end
         if (w_hit) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_chk_idx;
         end
      end
   end

   // Operand index capture at accept and read-data capture for TLBRD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_idx    <= ZERO_IDX;
         r_rd_issued <= 1'b0;
         r_cap_e     <= 1'b0;
         r_cap_vpn   <= ZERO_VPN;
      end else if (w_accept) begin
         r_op_idx    <= (w_op == OP_FILL) ? r_fill_cnt : csr_index;
         r_rd_issued <= 1'b0;
      end else if (r_state == ST_RD_WAIT) begin
         r_rd_issued <= 1'b1;
         if (r_rd_issued) begin
            r_cap_e   <= tlb_rd_e;
            r_cap_vpn <= tlb_rd_vpn;
         end
      end
   end

endmodule
